// File: rtl/mac_pkg.sv
// mac_pkg: shared constants, FSM state encoding and width checks for the
// tiled multiply-accumulate unit.
//   TILE_W     : tile width in bits (one 8x8 product per cycle)
//   DEF_W      : default operand width
//   DEF_ACC_W  : default accumulator width
//   state_t    : IDLE / MUL / ACC / DONE
//   widths_ok  : elaboration-time legality check for (W, ACC_W)
package mac_pkg;

    localparam int unsigned TILE_W    = 8;
    localparam int unsigned DEF_W     = 16;
    localparam int unsigned DEF_ACC_W = 36;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Operands must be whole tiles and the accumulator must hold a full product.
    function automatic bit widths_ok(input int unsigned w, input int unsigned acc_w);
        return (w >= TILE_W) && ((w % TILE_W) == 0) && (acc_w >= 2 * w);
    endfunction

endpackage

// File: rtl/mac_tile8x8.sv
// mac_tile8x8: combinational 8x8 unsigned multiplier, Wallace-tree reduction
// of the eight partial-product rows with 3:2 compressors, then one final add.
// Ports:
//   i_a      [7:0]  multiplicand tile
//   i_b      [7:0]  multiplier tile
//   o_prod_c [15:0] i_a * i_b (combinational)
module mac_tile8x8
    import mac_pkg::*;
(
    input  logic [TILE_W-1:0]   i_a,
    input  logic [TILE_W-1:0]   i_b,
    output logic [2*TILE_W-1:0] o_prod_c
);

    localparam int unsigned PW = 2 * TILE_W;

    // 3:2 carry-save compressor on whole rows; returns {carry, sum}.
    // Carries beyond bit PW-1 are dropped: the true product fits in PW bits.
    function automatic logic [2*PW-1:0] csa(input logic [PW-1:0] x,
                                            input logic [PW-1:0] y,
                                            input logic [PW-1:0] z);
        logic [PW-1:0] s;
        logic [PW-1:0] c;
        s = x ^ y ^ z;
        c = ((x & y) | (x & z) | (y & z)) << 1;
        return {c, s};
    endfunction

    logic [PW-1:0] w_pp [TILE_W];

    for (genvar k = 0; k < TILE_W; k++) begin : g_pp
        assign w_pp[k] = i_b[k] ? (PW'(i_a) << k) : '0;
    end

    logic [PW-1:0] w_s0, w_c0, w_s1, w_c1;
    logic [PW-1:0] w_s2, w_c2, w_s3, w_c3;
    logic [PW-1:0] w_s4, w_c4, w_s5, w_c5;

    // Layer 1: 8 rows -> 6
    assign {w_c0, w_s0} = csa(w_pp[0], w_pp[1], w_pp[2]);
    assign {w_c1, w_s1} = csa(w_pp[3], w_pp[4], w_pp[5]);
    // Layer 2: 6 rows -> 4
    assign {w_c2, w_s2} = csa(w_s0, w_c0, w_s1);
    assign {w_c3, w_s3} = csa(w_c1, w_pp[6], w_pp[7]);
    // Layer 3: 4 rows -> 3
    assign {w_c4, w_s4} = csa(w_s2, w_c2, w_s3);
    // Layer 4: 3 rows -> 2
    assign {w_c5, w_s5} = csa(w_s4, w_c4, w_c3);

    assign o_prod_c = w_s5 + w_c5;

endmodule

// File: rtl/mac_tiled_acc.sv
// mac_tiled_acc: multi-cycle unsigned multiply-accumulate. Each W-bit operand
// is split into 8-bit tiles; one tile product per cycle is shift-added into a
// 2W-bit product register, which is then folded into a sticky accumulator.
// Build option: define MAC_SAT_EN to saturate out_acc on overflow instead of
// wrapping (handshake timing is identical in both builds).
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   operand handshake
//   in_a, in_b  [W]       unsigned operands, latched on acceptance
//   in_clr                start a new accumulation (acc := a*b)
//   out_valid / out_ready result handshake
//   out_acc     [ACC_W]   accumulator
//   out_ovf               sticky overflow since last clear
module mac_tiled_acc
    import mac_pkg::*;
#(
    parameter int unsigned W     = DEF_W,
    parameter int unsigned ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf
);

    localparam int unsigned N     = W / TILE_W;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PW    = 2 * W;

    if (!widths_ok(W, ACC_W)) begin : g_cfg_err
        $error("mac_tiled_acc: W must be a multiple of 8 (>= 8) and ACC_W >= 2*W");
    end

    state_t           r_state;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic             r_clr;
    logic [PW-1:0]    r_prod;
    logic [IDX_W-1:0] r_i;
    logic [IDX_W-1:0] r_j;

    logic [TILE_W-1:0]   w_a_tile;
    logic [TILE_W-1:0]   w_b_tile;
    logic [2*TILE_W-1:0] w_tile_p;
    logic [PW-1:0]       w_tile_sh;
    logic                w_last_j;
    logic                w_last_i;
    logic [ACC_W-1:0]    w_base;
    logic [ACC_W:0]      w_sum;
    logic [ACC_W-1:0]    w_acc_next;

    // Tile selection and weighting for the current (i, j) pair.
    assign w_a_tile  = TILE_W'(r_a >> (TILE_W * 32'(r_i)));
    assign w_b_tile  = TILE_W'(r_b >> (TILE_W * 32'(r_j)));
    assign w_tile_sh = PW'(w_tile_p) << (TILE_W * (32'(r_i) + 32'(r_j)));
    assign w_last_j  = (r_j == IDX_W'(N - 1));
    assign w_last_i  = (r_i == IDX_W'(N - 1));

    mac_tile8x8 u_tile (
        .i_a      (w_a_tile),
        .i_b      (w_b_tile),
        .o_prod_c (w_tile_p)
    );

    // Accumulate with one guard bit; the guard bit is the overflow flag.
    assign w_base = r_clr ? '0 : out_acc;
    assign w_sum  = (ACC_W+1)'(w_base) + (ACC_W+1)'(r_prod);

    always_comb begin
        w_acc_next = w_sum[ACC_W-1:0];
`ifdef MAC_SAT_EN
        if (w_sum[ACC_W]) begin
            w_acc_next = '1;
        end
`endif
    end

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_ovf   <= 1'b0;
            r_prod    <= '0;
            r_i       <= '0;
            r_j       <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_clr     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        r_a      <= in_a;
                        r_b      <= in_b;
                        r_clr    <= in_clr;
                        r_prod   <= '0;
                        r_i      <= '0;
                        r_j      <= '0;
                        in_ready <= 1'b0;
                        r_state  <= MUL;
                    end
                end
                MUL: begin
                    r_prod <= r_prod + w_tile_sh;
                    // j is the inner index; i advances when j wraps.
                    if (w_last_j) begin
                        r_j <= '0;
                        if (w_last_i) begin
                            r_i     <= '0;
                            r_state <= ACC;
                        end else begin
                            r_i <= r_i + IDX_W'(1);
                        end
                    end else begin
                        r_j <= r_j + IDX_W'(1);
                    end
                end
                ACC: begin
                    out_acc   <= w_acc_next;
                    out_ovf   <= (r_clr ? 1'b0 : out_ovf) | w_sum[ACC_W];
                    out_valid <= 1'b1;
                    r_state   <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mac_tiled_acc.md
Name: mac_tiled_acc

Overview:
Parametrised multi-cycle multiply-accumulate unit with 36-bit accumulator default, successor to the fixed 16x16 Wallace product block. Operands of width W are split into 8-bit tiles. One 8x8 tile product is formed per cycle and shift-added into a 2W-bit product register, then folded into a sticky accumulator. Valid/ready handshakes on input and output let it sit between operand fetch and a result sink in the MAC datapath.

Parameters:
W, 16, operand width; must be a multiple of 8, minimum 8
ACC_W, 36, accumulator width; must be >= 2*W
N (localparam), W/8, tiles per operand

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair offered
in_ready  out  1  block can accept operands
in_a  in  W  multiplicand, unsigned
in_b  in  W  multiplier, unsigned
in_clr  in  1  start new accumulation: acc := a*b instead of acc + a*b
out_valid  out  1  accumulator result available
out_ready  in  1  sink accepts result
out_acc  out  ACC_W  accumulator register
out_ovf  out  1  sticky overflow since last clear

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. Reset forces state=IDLE, in_ready=1, out_valid=0, out_acc=0, out_ovf=0, product register=0, tile indices=0.
- FSM states: IDLE, MUL, ACC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch a, b and clr.
  - Clear the product register, set i=0, j=0, and go to MUL.
- MUL:
  - in_ready=0.
  - Each cycle: prod += tile(a,i)*tile(b,j) << 8*(i+j).
  - tile(x,k) = x[8k+7:8k].
  - Increment j first; on j wrap (j==N-1), increment i.
  - After the N*N-th tile, go to ACC.
- ACC:
  - sum = (clr ? 0 : out_acc) + zero-extended prod, computed at ACC_W+1 bits.
  - out_acc := sum[ACC_W-1:0].
  - out_ovf := (clr ? 0 : out_ovf) | sum[ACC_W].
  - Go to DONE.
- DONE:
  - out_valid=1.
  - out_acc and out_ovf are held stable until out_ready=1.
  - On out_valid&out_ready, go to IDLE.
  - in_valid is ignored (in_ready=0).
- Latency: the handshake edge to the out_valid rise is N*N+1 cycles (5 for W=16).
- Throughput: one operation per N*N+3 cycles when out_ready is held high.
- Product arithmetic: the 2W-bit product never overflows. Overflow exists only at the accumulator.
- out_acc is visible outside DONE but is meaningful only while out_valid=1.
- Reset asserted mid-operation aborts immediately. No partial result is produced.
- in_a and in_b may change freely after acceptance; only the latched copies are used.

Optional Feature:
MAC_SAT_EN
- Defined: on sum[ACC_W]=1, out_acc := all ones (saturate). out_ovf is still set.
- Undefined: out_acc wraps modulo 2^ACC_W. out_ovf is set as described above.
- Both builds share identical handshake timing.

Decomposition:
- Package mac_pkg:
  - state encoding typedef (IDLE/MUL/ACC/DONE)
  - TILE_W=8
  - default W/ACC_W constants
  - elaboration-time width checks (W%8==0, ACC_W>=2W)
- Sub-module mac_tile8x8: combinational 8x8 unsigned multiplier, 16-bit out, Wallace tree. It is instantiated once in mac_tiled_acc and time-shared across tiles.
- The FSM, tile indexing and accumulator stay in the top.

Test Plan:
- Reset: rst_n=0 -> in_ready=1, out_valid=0, out_acc=0, out_ovf=0. This holds again after release.
- Clear-multiply: clr=1, a=0xFFFF, b=0xFFFF -> out_valid 5 cycles after accept, out_acc=0x0FFFE0001, out_ovf=0.
- Accumulate: then clr=0, a=3, b=5 -> out_acc=0x0FFFE0010. Then clr=1, a=0x1234, b=0x0010 -> out_acc=0x000012340.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while in_valid=1 -> out_valid stays 1, out_acc stable, in_ready=0, no operand consumed. Release -> IDLE next cycle.
- Overflow: clr=1 then 16 further accumulations of 0xFFFF*0xFFFF (17 total) -> wrap build gives out_acc=0x0FFDE0011, out_ovf=1. MAC_SAT_EN build gives out_acc=0xFFFFFFFFF, out_ovf=1. A following clr=1 op clears out_ovf.
- Mid-op reset: assert rst_n=0 during the third MUL cycle -> state IDLE asynchronously, out_acc=0, out_valid=0. The next op with clr=1, a=2, b=7 gives out_acc=14.
